// File: rtl/instr_fetch.sv
// Instruction fetch controller: reads the instruction word at pc from memory,
// hands it to the instruction register and advances or redirects the pc.
// Optional feature macro FETCH_TIMEOUT_EN: abort a memory read that is not
// answered within TIMEOUT_CYCLES WAIT cycles and pulse fetch_err.
//
// state  | meaning
// S_IDLE | waiting for fetch_req or pc_load
// S_WAIT | mem_rd held high, waiting for mem_ready
// S_DONE | ir_write strobe cycle, pc update on exit
module instr_fetch #(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic        pc_load,
  input  logic [15:0] pc_load_val,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  output logic [15:0] ir_data,
  output logic        ir_write,
  output logic [15:0] pc,
  output logic        busy,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt;
  logic        r_mem_rd, w_mem_rd_nxt;
  logic [15:0] r_mem_addr, w_mem_addr_nxt;
  logic [15:0] r_ir_data, w_ir_data_nxt;
  logic        r_ir_write, w_ir_write_nxt;
  logic        r_busy;
  logic        r_pend_vld, w_pend_vld_nxt;
  logic [15:0] r_pend_pc, w_pend_pc_nxt;
  logic        w_redir_vld;
  logic [15:0] w_redir_pc;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_tmo_cnt;
  logic        r_fetch_err, w_err_nxt;
  logic        w_tmo_expire;

  assign w_tmo_expire = (r_state == S_WAIT) && (r_tmo_cnt == 16'd0) && !mem_ready;
`endif

  // A redirect arriving in the same cycle as the pc update wins over an older pending one.
  assign w_redir_vld = pc_load | r_pend_vld;
  assign w_redir_pc  = pc_load ? pc_load_val : r_pend_pc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_mem_rd_nxt   = r_mem_rd;
    w_mem_addr_nxt = r_mem_addr;
    w_ir_data_nxt  = r_ir_data;
    w_ir_write_nxt = 1'b0;
    w_pend_vld_nxt = r_pend_vld;
    w_pend_pc_nxt  = r_pend_pc;
`ifdef FETCH_TIMEOUT_EN
    w_err_nxt      = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (pc_load) begin
          w_pc_nxt = pc_load_val;
        end else if (fetch_req) begin
          w_mem_rd_nxt   = 1'b1;
          w_mem_addr_nxt = r_pc;
          w_state_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (pc_load) begin
          w_pend_vld_nxt = 1'b1;
          w_pend_pc_nxt  = pc_load_val;
        end
        if (mem_ready) begin
          w_ir_data_nxt  = mem_rdata;
          w_mem_rd_nxt   = 1'b0;
          w_ir_write_nxt = 1'b1;
          w_state_nxt    = S_DONE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (w_tmo_expire) begin
          w_mem_rd_nxt   = 1'b0;
          w_err_nxt      = 1'b1;
          w_pend_vld_nxt = 1'b0;
          if (w_redir_vld) w_pc_nxt = w_redir_pc;
          w_state_nxt    = S_IDLE;
        end
`endif
      end
      S_DONE: begin
        w_pc_nxt       = w_redir_vld ? w_redir_pc : r_pc + 16'd1;
        w_pend_vld_nxt = 1'b0;
        w_state_nxt    = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered outputs and pending redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= 16'h0000;
      r_ir_data  <= 16'h0000;
      r_ir_write <= 1'b0;
      r_busy     <= 1'b0;
      r_pend_vld <= 1'b0;
      r_pend_pc  <= 16'h0000;
    end else begin
      r_pc       <= w_pc_nxt;
      r_mem_rd   <= w_mem_rd_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_ir_data  <= w_ir_data_nxt;
      r_ir_write <= w_ir_write_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_pend_vld <= w_pend_vld_nxt;
      r_pend_pc  <= w_pend_pc_nxt;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // WAIT-cycle down-counter; reloaded while idle, expiry detected at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt   <= 16'h0000;
      r_fetch_err <= 1'b0;
    end else begin
      r_fetch_err <= w_err_nxt;
      if (r_state != S_WAIT)      r_tmo_cnt <= TMO_LOAD;
      else if (r_tmo_cnt != 16'd0) r_tmo_cnt <= r_tmo_cnt - 16'd1;
    end
  end

  assign fetch_err = r_fetch_err;
`else
  assign fetch_err = 1'b0;
`endif

  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_mem_addr;
  assign ir_data  = r_ir_data;
  assign ir_write = r_ir_write;
  assign pc       = r_pc;
  assign busy     = r_busy;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed fetch sequences; expected instruction words
// and fetch addresses are queued when a fetch is issued and checked by a
// monitor whenever ir_write is seen.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] ir_data;
  logic        ir_write;
  logic [15:0] pc;
  logic        busy;
  logic        fetch_err;

  int n_vec = 0;
  int n_err = 0;
  int err_seen = 0;
  logic [31:0] sb_q[$];

  instr_fetch #(.RESET_PC(16'h0000), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .ir_data(ir_data), .ir_write(ir_write),
    .pc(pc), .busy(busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every ir_write must match the oldest outstanding fetch.
  always @(negedge clk) begin
    logic [31:0] e;
    if (ir_write === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ir_write: ir_data %h with no fetch outstanding at %0t", ir_data, $time);
      end else begin
        e = sb_q.pop_front();
        chk("ir_data", ir_data, e[15:0]);
        chk("fetch_addr", mem_addr, e[31:16]);
      end
    end
    if (fetch_err === 1'b1) err_seen++;
  end

  // One complete fetch; optional redirects and fetch_req held during WAIT.
  task automatic do_fetch(input logic [15:0] addr, input logic [15:0] data, input int dly,
                          input int n_redir, input logic [15:0] ra, input logic [15:0] rb,
                          input logic hold_req);
    sb_q.push_back({addr, data});
    fetch_req = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(negedge clk);
    chk("mem_rd_wait", {15'd0, mem_rd}, 16'd1);
    chk("mem_addr_wait", mem_addr, addr);
    for (int i = 0; i < dly; i++) begin
      if (hold_req) fetch_req = 1'b1;
      if (n_redir > 0 && i == 0)       begin pc_load = 1'b1; pc_load_val = ra; end
      if (n_redir > 1 && i == dly - 1) begin pc_load = 1'b1; pc_load_val = rb; end
      @(posedge clk); #1;
      pc_load = 1'b0;
    end
    fetch_req = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = data;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;
    @(negedge clk);
    chk("ir_write_latency", {15'd0, ir_write}, 16'd1);
    chk("mem_rd_done", {15'd0, mem_rd}, 16'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_after_done", {15'd0, busy}, 16'd0);
  endtask

  initial begin
    rst = 1'b1; fetch_req = 1'b0; pc_load = 1'b0; pc_load_val = 16'h0000;
    mem_rdata = 16'h0000; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_mem_rd", {15'd0, mem_rd}, 16'd0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_ir_data", ir_data, 16'h0000);
    chk("rst_ir_write", {15'd0, ir_write}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_fetch_err", {15'd0, fetch_err}, 16'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic fetch, memory answers in the first WAIT cycle.
    do_fetch(16'h0000, 16'h8B48, 0, 0, 16'h0, 16'h0, 1'b0);
    chk("pc_after_first", pc, 16'h0001);

    // Wrap from 0xFFFF.
    pc_load = 1'b1; pc_load_val = 16'hFFFF;
    @(posedge clk); #1;
    pc_load = 1'b0;
    do_fetch(16'hFFFF, 16'h2BC9, 0, 0, 16'h0, 16'h0, 1'b0);
    chk("pc_wrap", pc, 16'h0000);

    // Two redirects during a 3-cycle WAIT, last wins; fetch_req in WAIT ignored.
    do_fetch(16'h0000, 16'h1234, 3, 2, 16'h0033, 16'h0040, 1'b1);
    chk("pc_redirect", pc, 16'h0040);
    do_fetch(16'h0040, 16'h0F0F, 1, 0, 16'h0, 16'h0, 1'b0);
    chk("pc_pend_cleared", pc, 16'h0041);

    // pc_load beats a same-cycle fetch_req in IDLE.
    pc_load = 1'b1; fetch_req = 1'b1; pc_load_val = 16'h0010;
    @(posedge clk); #1;
    pc_load = 1'b0; fetch_req = 1'b0;
    @(negedge clk);
    chk("load_prio_mem_rd", {15'd0, mem_rd}, 16'd0);
    chk("load_prio_busy", {15'd0, busy}, 16'd0);
    chk("load_prio_pc", pc, 16'h0010);
    do_fetch(16'h0010, 16'h5A5A, 2, 0, 16'h0, 16'h0, 1'b0);
    chk("pc_after_load", pc, 16'h0011);

    // mem_ready in IDLE is ignored and ir_data holds.
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rdata = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("idle_ready_busy", {15'd0, busy}, 16'd0);
    chk("ir_data_hold", ir_data, 16'h5A5A);
    chk("idle_ready_pc", pc, 16'h0011);

    // Unanswered read.
    fetch_req = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("tmo_last_wait_rd", {15'd0, mem_rd}, 16'd1);
    chk("tmo_last_wait_err", {15'd0, fetch_err}, 16'd0);
    @(negedge clk);
    chk("tmo_err_pulse", {15'd0, fetch_err}, 16'd1);
    chk("tmo_mem_rd", {15'd0, mem_rd}, 16'd0);
    chk("tmo_busy", {15'd0, busy}, 16'd0);
    chk("tmo_pc", pc, 16'h0011);
    @(negedge clk);
    chk("tmo_err_one_cycle", {15'd0, fetch_err}, 16'd0);
    // Answer arriving exactly at expiry completes normally.
    do_fetch(16'h0011, 16'h7777, 15, 0, 16'h0, 16'h0, 1'b0);
    chk("tmo_edge_pc", pc, 16'h0012);
    chk("err_count", 16'(err_seen), 16'd1);
`else
    begin
      int hi_cnt = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (mem_rd === 1'b1) hi_cnt++;
      end
      chk("no_tmo_rd_held", 16'(hi_cnt), 16'd100);
    end
    sb_q.push_back({16'h0011, 16'h7777});
    mem_ready = 1'b1; mem_rdata = 16'h7777;
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rdata = 16'h0000;
    @(negedge clk);
    chk("late_ir_write", {15'd0, ir_write}, 16'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("late_pc", pc, 16'h0012);
    chk("err_count", 16'(err_seen), 16'd0);
`endif

    // Reset in the middle of WAIT.
    pc_load = 1'b1; pc_load_val = 16'h0005;
    @(posedge clk); #1;
    pc_load = 1'b0;
    @(negedge clk);
    chk("pc_preload5", pc, 16'h0005);
    fetch_req = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(negedge clk);
    chk("rst_wait_rd", {15'd0, mem_rd}, 16'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_abort_busy", {15'd0, busy}, 16'd0);
    chk("rst_abort_rd", {15'd0, mem_rd}, 16'd0);
    chk("rst_abort_pc", pc, 16'h0000);
    mem_ready = 1'b1; mem_rdata = 16'hDEAD;
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rdata = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_abort_pc_late", pc, 16'h0000);
    chk("rst_abort_ir_data", ir_data, 16'h0000);

    chk("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 100000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded by reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, maximum WAIT cycles before abort; used only with FETCH_TIMEOUT_EN.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 fetch_req  input  1  control-unit request to fetch the next instruction; sampled in IDLE only.
REQ-006 pc_load  input  1  redirect strobe for branch or jump.
REQ-007 pc_load_val  input  16  redirect target, word address.
REQ-008 mem_rdata  input  16  instruction word from memory; valid when mem_ready=1.
REQ-009 mem_ready  input  1  memory read-complete strobe.
REQ-010 mem_rd  output  1  memory read request; level-held until accepted.
REQ-011 mem_addr  output  16  read address; stable while mem_rd=1.
REQ-012 ir_data  output  16  registered instruction word to the instruction register (D_MemData).
REQ-013 ir_write  output  1  one-cycle load strobe to the instruction register (C_IRWrite).
REQ-014 pc  output  16  current program counter.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 fetch_err  output  1  one-cycle pulse on fetch timeout.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT and DONE, with all outputs registered.
REQ-018 IDLE with fetch_req=1 and pc_load=0 SHALL set mem_addr=pc and mem_rd=1, then go to WAIT.
REQ-019 WAIT SHALL hold mem_rd=1 and mem_addr constant until mem_ready=1 is sampled.
REQ-020 WAIT with mem_ready=1 SHALL capture mem_rdata into ir_data, drop mem_rd, and go to DONE.
REQ-021 DONE SHALL assert ir_write for exactly one cycle, then return to IDLE.
REQ-022 In DONE, pc SHALL become pending target if a redirect is pending, else pc+1.
REQ-023 Fetch latency SHALL be: fetch_req cycle N; mem_rd high from N+1; mem_ready at cycle M; ir_write at M+1; pc updated and visible at M+2.
REQ-024 Mem_ready seen combinationally in the first WAIT cycle SHALL give ir_write at N+2.
REQ-025 ir_data SHALL hold its value between fetches; ir_write SHALL be 0 outside DONE.
REQ-026 PC arithmetic SHALL be 16-bit modulo, so 16'hFFFF+1 = 16'h0000.
REQ-027 pc_load in IDLE SHALL load pc_load_val on the next edge and SHALL take priority over a same-cycle fetch_req, which is dropped.
REQ-028 pc_load in WAIT or DONE SHALL store pc_load_val as a pending redirect; the last load received wins.
REQ-029 A pending redirect SHALL apply at the DONE update or the timeout abort, then clear.
REQ-030 fetch_req in WAIT or DONE SHALL be ignored; the requester SHALL retry after busy falls.
REQ-031 mem_ready outside WAIT SHALL be ignored.

Reset
REQ-032 rst=1 SHALL force IDLE, pc=RESET_PC, mem_rd=0, mem_addr=0, ir_data=0, ir_write=0, fetch_err=0, and SHALL clear the pending redirect and timeout counter.
REQ-033 rst in WAIT SHALL abort the read, with no ir_write and no pc increment; rst SHALL take priority over all inputs.

Configuration
REQ-034 With macro FETCH_TIMEOUT_EN defined, a counter SHALL count WAIT cycles.
REQ-035 Under FETCH_TIMEOUT_EN, TIMEOUT_CYCLES WAIT cycles without mem_ready SHALL cause: mem_rd=0, a one-cycle fetch_err pulse, pc unchanged (or pending target if one exists), no ir_write, and a return to IDLE.
REQ-036 Under FETCH_TIMEOUT_EN, mem_ready arriving in the same cycle the count expires SHALL complete normally with no fetch_err.
REQ-037 Without FETCH_TIMEOUT_EN, WAIT SHALL wait indefinitely, fetch_err SHALL be tied 0, and no counter logic SHALL exist.

Verification
REQ-038 Reset, then fetch_req with mem_ready one cycle later and mem_rdata=16'h8B48 -> mem_addr=0, ir_data=16'h8B48, one ir_write pulse, pc=1.
REQ-039 pc_load_val=16'hFFFF then fetch with mem_rdata=16'h2BC9 -> mem_addr=16'hFFFF, ir_write pulse, pc wraps to 16'h0000.
REQ-040 pc_load_val=16'h0040 asserted during WAIT, memory delayed 3 cycles -> ir_write pulse once, pc=16'h0040 (not old pc+1), busy low after DONE.
REQ-041 pc_load and fetch_req together in IDLE with pc_load_val=16'h0010 -> no mem_rd, pc=16'h0010; the next fetch_req reads address 16'h0010.
REQ-042 With FETCH_TIMEOUT_EN and mem_ready never asserted -> fetch_err pulses after 16 WAIT cycles, pc unchanged, no ir_write. Without the macro, mem_rd stays high for 100 cycles.
REQ-043 rst asserted mid-WAIT at pc=5 -> next cycle IDLE, mem_rd=0, pc=RESET_PC; a later mem_ready produces no ir_write.
